// File: rtl/i2c_byte_master.sv
// Byte-level I2C master engine: START, STOP, 8-bit WRITE/READ with ninth-bit ack.
// Open-drain lines are driven as output enables; SCL stretching is honoured in q1/q2.
module i2c_byte_master #(
  parameter int unsigned CLK_DIV = 125
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  input  logic       cmd_ack,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_nack,
  output logic       busy,
  input  logic       sda_in,
  input  logic       scl_in,
  output logic       sda_oe,
  output logic       scl_oe
);

  localparam int unsigned DivW = $clog2(CLK_DIV);
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

  localparam logic [1:0] OpStart = 2'b00;
  localparam logic [1:0] OpStop  = 2'b01;
  localparam logic [1:0] OpWrite = 2'b10;
  localparam logic [1:0] OpRead  = 2'b11;

  typedef enum logic [2:0] {StIdle, StStart, StBit, StStop, StDone} state_e;

  state_e          state_q;
  logic [1:0]      phase_q;
  logic [DivW-1:0] div_q, div_d;
  logic [3:0]      bit_q;
  logic [1:0]      op_q;
  logic [7:0]      shreg_q;
  logic            ack_q;
  logic            sda_oe_q, scl_oe_q;
  logic            rsp_valid_q, rsp_nack_q;
  logic [7:0]      rsp_data_q;

  logic running, hold, tick;

  // A slave holding SCL low while it is released freezes the quarter divider.
  always_comb begin
    running = (state_q == StStart) || (state_q == StBit) || (state_q == StStop);
    hold    = ((phase_q == 2'd1) || (phase_q == 2'd2)) && !scl_in;
    tick    = running && !hold && (div_q == DivLast);
    div_d   = div_q;
    if (!running) begin
      div_d = '0;
    end else if (tick) begin
      div_d = '0;
    end else if (!hold) begin
      div_d = div_q + DivW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      phase_q     <= 2'd0;
      div_q       <= '0;
      bit_q       <= 4'd0;
      op_q        <= OpStart;
      shreg_q     <= 8'h00;
      ack_q       <= 1'b0;
      sda_oe_q    <= 1'b0;
      scl_oe_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      rsp_nack_q  <= 1'b0;
    end else begin
      div_q       <= div_d;
      rsp_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            op_q    <= cmd_op;
            shreg_q <= cmd_data;
            ack_q   <= cmd_ack;
            phase_q <= 2'd0;
            bit_q   <= 4'd0;
            case (cmd_op)
              OpStart: begin
                state_q  <= StStart;
                sda_oe_q <= 1'b0;
                scl_oe_q <= 1'b0;
              end
              OpStop: begin
                state_q  <= StStop;
                sda_oe_q <= 1'b1;
                scl_oe_q <= 1'b1;
              end
              OpWrite: begin
                state_q  <= StBit;
                scl_oe_q <= 1'b1;
                sda_oe_q <= ~cmd_data[7];
              end
              default: begin
                state_q  <= StBit;
                scl_oe_q <= 1'b1;
                sda_oe_q <= 1'b0;
              end
            endcase
          end
        end
        // Actions below are keyed on the phase that is ending at this tick.
        StStart: begin
          if (tick) begin
            phase_q <= phase_q + 2'd1;
            case (phase_q)
              2'd1: sda_oe_q <= 1'b1;
              2'd2: scl_oe_q <= 1'b1;
              2'd3: begin
                state_q     <= StDone;
                rsp_valid_q <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        StStop: begin
          if (tick) begin
            phase_q <= phase_q + 2'd1;
            case (phase_q)
              2'd0: scl_oe_q <= 1'b0;
              2'd1: sda_oe_q <= 1'b0;
              2'd3: begin
                state_q     <= StDone;
                rsp_valid_q <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        StBit: begin
          if (tick) begin
            phase_q <= phase_q + 2'd1;
            case (phase_q)
              2'd0: scl_oe_q <= 1'b0;
              2'd2: begin
                scl_oe_q <= 1'b1;
                if (op_q == OpWrite && bit_q == 4'd8) begin
                  rsp_nack_q <= sda_in;
                end
                if (op_q == OpRead && bit_q != 4'd8) begin
                  shreg_q <= {shreg_q[6:0], sda_in};
                end
              end
              2'd3: begin
                if (bit_q == 4'd8) begin
                  state_q     <= StDone;
                  rsp_valid_q <= 1'b1;
                  if (op_q == OpRead) begin
                    rsp_data_q <= shreg_q;
                  end
                end else begin
                  bit_q <= bit_q + 4'd1;
                  if (op_q == OpWrite) begin
                    shreg_q  <= {shreg_q[6:0], 1'b0};
                    sda_oe_q <= (bit_q == 4'd7) ? 1'b0 : ~shreg_q[6];
                  end else begin
                    sda_oe_q <= (bit_q == 4'd7) ? ~ack_q : 1'b0;
                  end
                end
              end
              default: ;
            endcase
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign busy      = ~cmd_ready;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_nack  = rsp_nack_q;
  assign sda_oe    = sda_oe_q;
  assign scl_oe    = scl_oe_q;

endmodule

// File: tb/tb_i2c_byte_master.sv
// Directed bench for i2c_byte_master with CLK_DIV=4: behavioural slave, scoreboard queues
// for expected SDA bits and responses, immediate assertions at every check.
module tb_i2c_byte_master;

  localparam logic [1:0] OpStart = 2'b00;
  localparam logic [1:0] OpStop  = 2'b01;
  localparam logic [1:0] OpWrite = 2'b10;
  localparam logic [1:0] OpRead  = 2'b11;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_ack = 1'b0;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_nack;
  logic       busy;
  logic       sda_in, scl_in, sda_oe, scl_oe;

  // Bench-side bus and slave
  logic       stretch = 1'b0;
  logic       slave_low = 1'b0;
  logic       scl_prev = 1'b1;
  bit         in_byte = 1'b0;
  bit         sl_read = 1'b0;
  logic       sl_nack = 1'b0;
  logic [7:0] sl_byte = 8'h00;
  int         rises = 0;
  logic       obs_bits [0:511];
  int         obs_wr = 0;

  // Scoreboard
  logic       exp_bits [$];
  logic [8:0] exp_rsp [$];
  logic [7:0] m_data = 8'h00;
  logic       m_nack = 1'b0;
  int         n_assert = 0;
  int         n_fail = 0;

  wire sda_line = ~sda_oe & ~slave_low;
  wire scl_line = ~scl_oe & ~stretch;
  assign sda_in = sda_line;
  assign scl_in = scl_line;

  i2c_byte_master #(.CLK_DIV(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_ack   (cmd_ack),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_nack  (rsp_nack),
    .busy      (busy),
    .sda_in    (sda_in),
    .scl_in    (scl_in),
    .sda_oe    (sda_oe),
    .scl_oe    (scl_oe)
  );

  always #5 clk = ~clk;

  function automatic logic slave_want(input int r);
    if (sl_read) return (r < 8) ? ~sl_byte[7-r] : 1'b0;
    return (r == 8) ? ~sl_nack : 1'b0;
  endfunction

  // Slave only changes SDA while SCL is low; every SCL rise inside a byte logs SDA.
  always @(negedge clk) begin
    if (!in_byte) begin
      rises     <= 0;
      slave_low <= 1'b0;
    end else if (scl_line && !scl_prev) begin
      obs_bits[obs_wr] <= sda_line;
      obs_wr           <= obs_wr + 1;
      rises            <= rises + 1;
    end else if (!scl_line) begin
      slave_low <= slave_want(rises);
    end
    scl_prev <= scl_line;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic to_idle();
    int n = 0;
    while (!cmd_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Called at #1 after an edge with the engine idle; returns in IDLE again.
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] data, input logic ack,
                         input int exp_lat, input bit mutate, input string tag);
    int n;
    int base;
    logic [8:0] er;
    chk({tag, " ready"}, 32'(cmd_ready), 32'd1);
    if (op == OpWrite) begin
      sl_read = 1'b0;
      for (int i = 0; i < 8; i++) exp_bits.push_back(data[7-i]);
      exp_bits.push_back(sl_nack);
      m_nack = sl_nack;
    end else if (op == OpRead) begin
      sl_read = 1'b1;
      for (int i = 0; i < 8; i++) exp_bits.push_back(sl_byte[7-i]);
      exp_bits.push_back(ack);
      m_data = sl_byte;
    end
    exp_rsp.push_back({m_data, m_nack});
    in_byte  = op[1];
    base     = obs_wr;
    cmd_op   = op;
    cmd_data = data;
    cmd_ack  = ack;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (mutate) begin
      cmd_op   = OpRead;
      cmd_data = ~data;
      cmd_ack  = ~ack;
    end
    n = 0;
    while (!rsp_valid && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " latency"}, n, exp_lat);
    er = exp_rsp.pop_front();
    chk({tag, " rsp_data"}, 32'(rsp_data), 32'(er[8:1]));
    chk({tag, " rsp_nack"}, 32'(rsp_nack), 32'(er[0]));
    in_byte = 1'b0;
    if (op[1]) begin
      chk({tag, " bit count"}, obs_wr - base, 9);
      for (int i = 0; i < 9; i++) begin
        chk($sformatf("%s sda bit %0d", tag, i), 32'(obs_bits[base+i]),
            32'(exp_bits.pop_front()));
      end
    end
    @(posedge clk); #1;
    chk({tag, " rsp pulse"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    int f_sda, f_scl, f_rsp, cnt, rdy;
    repeat (3) @(posedge clk);
    #1;
    chk("reset sda_oe", 32'(sda_oe), 0);
    chk("reset scl_oe", 32'(scl_oe), 0);
    chk("reset cmd_ready", 32'(cmd_ready), 1);
    chk("reset busy", 32'(busy), 0);
    chk("reset rsp_valid", 32'(rsp_valid), 0);
    chk("reset rsp_data", 32'(rsp_data), 0);
    chk("reset rsp_nack", 32'(rsp_nack), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // START timing from the acceptance edge
    f_sda = -1; f_scl = -1; f_rsp = -1;
    cmd_op = OpStart; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("start busy", 32'(busy), 1);
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (sda_oe && f_sda < 0) f_sda = n;
      if (scl_oe && f_scl < 0) f_scl = n;
      if (rsp_valid && f_rsp < 0) f_rsp = n;
    end
    chk("start sda_oe rise", f_sda, 8);
    chk("start scl_oe rise", f_scl, 12);
    chk("start rsp_valid", f_rsp, 16);
    to_idle();

    sl_nack = 1'b0;
    run_cmd(OpWrite, 8'hA5, 1'b0, 144, 1'b0, "write A5 ack");
    chk("scl held low after write", 32'(scl_oe), 1);
    sl_nack = 1'b1;
    run_cmd(OpWrite, 8'h5A, 1'b0, 144, 1'b0, "write 5A nack");
    sl_byte = 8'h3C;
    run_cmd(OpRead, 8'h00, 1'b1, 144, 1'b0, "read 3C nack");
    sl_byte = 8'h81;
    run_cmd(OpRead, 8'h00, 1'b0, 144, 1'b0, "read 81 ack");
    run_cmd(OpStop, 8'h00, 1'b0, 16, 1'b0, "stop");
    chk("stop sda released", 32'(sda_oe), 0);
    chk("stop scl released", 32'(scl_oe), 0);

    // Stretch: slave holds SCL low 20 cycles from bit 3 q1 of WRITE 0xFF
    run_cmd(OpStart, 8'h00, 1'b0, 16, 1'b0, "start 2");
    sl_nack = 1'b0;
    fork
      begin
        repeat (53) @(posedge clk);
        #1 stretch = 1'b1;
        repeat (20) @(posedge clk);
        #1 stretch = 1'b0;
      end
    join_none
    run_cmd(OpWrite, 8'hFF, 1'b0, 164, 1'b1, "write FF stretch");

    // Reset at cycle 50 of a WRITE aborts silently
    run_cmd(OpStart, 8'h00, 1'b0, 16, 1'b0, "start 3");
    sl_read = 1'b0;
    in_byte = 1'b1;
    cmd_op = OpWrite; cmd_data = 8'h00; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (48) @(posedge clk);
    #1;
    chk("abort busy before reset", 32'(busy), 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort sda_oe", 32'(sda_oe), 0);
    chk("abort scl_oe", 32'(scl_oe), 0);
    chk("abort cmd_ready", 32'(cmd_ready), 1);
    chk("abort busy", 32'(busy), 0);
    chk("abort rsp_data", 32'(rsp_data), 0);
    chk("abort rsp_nack", 32'(rsp_nack), 0);
    reset = 1'b0;
    in_byte = 1'b0;
    cnt = 0;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #1;
      if (rsp_valid) cnt++;
    end
    chk("abort no rsp_valid", cnt, 0);

    // cmd_valid held high: one acceptance per IDLE visit
    to_idle();
    cnt = 0; rdy = 0;
    cmd_op = OpStart; cmd_valid = 1'b1;
    for (int n = 0; n <= 53; n++) begin
      @(posedge clk); #1;
      if (rsp_valid) cnt++;
      if (cmd_ready) rdy++;
    end
    cmd_valid = 1'b0;
    chk("held valid rsp count", cnt, 3);
    chk("held valid idle count", rdy, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_byte_master.md
I2C_BYTE_MASTER -- requirements
Module: i2c_byte_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 125, giving clk cycles per SCL quarter-period (50 MHz -> 100 kHz); legal range >= 2.
REQ-002 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port cmd_valid  input  1  command offered.
REQ-005 SHALL have port cmd_ready  output  1  engine idle; command accepted on the cycle where cmd_valid & cmd_ready.
REQ-006 SHALL have port cmd_op  input  2  operation: 00 START, 01 STOP, 10 WRITE, 11 READ.
REQ-007 SHALL have port cmd_data  input  8  byte for WRITE.
REQ-008 SHALL have port cmd_ack  input  1  ninth bit master sends on READ (0 = ACK, 1 = NACK).
REQ-009 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-010 SHALL have port rsp_data  output  8  byte received by READ.
REQ-011 SHALL have port rsp_nack  output  1  ninth bit sampled on WRITE (1 = slave NACK).
REQ-012 SHALL have port busy  output  1  high whenever a command is in progress.
REQ-013 SHALL have ports sda_in, scl_in  input  1 each  bus line levels.
REQ-014 SHALL have ports sda_oe, scl_oe  output  1 each  1 = pull line low, 0 = release (open-drain).

Function
REQ-015 SHALL divide clk by a counter reaching CLK_DIV-1, generating one quarter tick; the phase index q0..q3 advances on each tick.
REQ-016 SHALL implement states IDLE, START, BIT, STOP, DONE; the state leaves IDLE only on acceptance, for START/STOP/BIT per cmd_op.
REQ-017 SHALL drive START as q0: sda_oe=0, scl_oe=0; q1: hold; q2: sda_oe=1; q3: scl_oe=1; then DONE.
REQ-018 SHALL drive STOP as q0: scl_oe=1, sda_oe=1; q1: scl_oe=0; q2: sda_oe=0; q3: hold; then DONE.
REQ-019 SHALL run BIT for 9 bits, MSB first; per bit q0: scl_oe=1, sda_oe set; q1: scl_oe=0; q2: SCL high; q3: scl_oe=1.
REQ-020 SHALL, in WRITE bits 0-7, set sda_oe = ~data bit; in bit 8 set sda_oe=0 and sample sda_in into rsp_nack.
REQ-021 SHALL, in READ bits 0-7, set sda_oe=0 and shift sda_in into rsp_data; in bit 8 set sda_oe = ~cmd_ack (latched at acceptance).
REQ-022 SHALL sample sda_in on the tick ending q2.
REQ-023 SHALL support clock stretching: during q1 and q2 the divider holds while scl_in=0, and counts only once scl_in=1.
REQ-024 SHALL latch cmd_op, cmd_data and cmd_ack at acceptance; input changes while busy are ignored.
REQ-025 SHALL take 4*CLK_DIV cycles for START/STOP and 36*CLK_DIV cycles for WRITE/READ from acceptance to DONE, plus stretch cycles.
REQ-026 SHALL, in DONE, pulse rsp_valid for exactly one cycle, then return to IDLE on the next cycle.
REQ-027 SHALL update rsp_data only on READ and rsp_nack only on WRITE; both hold their values until the next such update.
REQ-028 SHALL drive cmd_ready=1 only in IDLE, and busy = ~cmd_ready.
REQ-029 SHALL keep sda_oe/scl_oe unchanged between commands, so SCL stays low after START/WRITE/READ until STOP.

Reset
REQ-030 SHALL, on reset, go to IDLE with sda_oe=0, scl_oe=0, cmd_ready=1, busy=0, rsp_valid=0, rsp_data=0x00, rsp_nack=0, and clear the divider and bit counters.
REQ-031 SHALL, on reset asserted mid-command, abort on the next edge with no rsp_valid, leaving both lines released.

Verification (CLK_DIV=4)
REQ-032 SHALL verify: START accepted at cycle 0 -> sda_oe rises at cycle 8, scl_oe at cycle 12, rsp_valid at cycle 16.
REQ-033 SHALL verify: WRITE 0xA5, slave ACKs -> SDA bit pattern 1,0,1,0,0,1,0,1, then rsp_valid at cycle 144 with rsp_nack=0.
REQ-034 SHALL verify: READ, cmd_ack=1, slave drives 0x3C -> rsp_data=0x3C, rsp_nack unchanged, sda_oe=0 during bit 8.
REQ-035 SHALL verify: slave holds scl_in low 20 cycles in bit 3 of WRITE 0xFF -> rsp_valid at cycle 164, WRITE 0xFF otherwise unaffected.
REQ-036 SHALL verify: reset at cycle 50 of a WRITE -> sda_oe=scl_oe=0 and cmd_ready=1 next cycle, no rsp_valid.
REQ-037 SHALL verify: cmd_valid held high while busy -> exactly one command is accepted per IDLE entry.
